// File: rtl/register_read_stage.sv
// register_read_stage
// Sits between the reservation-station issue port and an execution unit.
// Presents source tags to a synchronous-read register file, resolves the
// operands one cycle later and holds them (tracking writebacks) until the
// execution unit takes the op. At most one op is in flight. Back-to-back
// issue gives one op per cycle.
//
// Optional feature: define RR_WB_BYPASS_EN to add writeback bypass
// comparators. These capture writebacks that land in the issue cycle and
// refresh operands that are waiting in HOLD. Without the macro the
// register file must be write-through, and held operands are frozen.
//
// `PHY_REG_NUM and `WB_WIDTH come from the surrounding build. Fallback
// values are provided here.

`ifndef PHY_REG_NUM
`define PHY_REG_NUM 64
`endif
`ifndef WB_WIDTH
`define WB_WIDTH 2
`endif

module register_read_stage #(
  parameter  int DATA_WIDTH    = 32,
  parameter  int PAYLOAD_WIDTH = 64,
  localparam int TAG_W         = $clog2(`PHY_REG_NUM),
  localparam int WB_W          = `WB_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic [TAG_W-1:0]           issue_psrc0_i,
  input  logic [TAG_W-1:0]           issue_psrc1_i,
  input  logic                       issue_psrc0_valid_i,
  input  logic                       issue_psrc1_valid_i,
  input  logic [PAYLOAD_WIDTH-1:0]   issue_payload_i,
  output logic [TAG_W-1:0]           rf_raddr0_o,
  output logic [TAG_W-1:0]           rf_raddr1_o,
  input  logic [DATA_WIDTH-1:0]      rf_rdata0_i,
  input  logic [DATA_WIDTH-1:0]      rf_rdata1_i,
  input  logic [WB_W-1:0]            wb_valid_i,
  input  logic [WB_W*TAG_W-1:0]      wb_pdest_i,
  input  logic [WB_W*DATA_WIDTH-1:0] wb_data_i,
  output logic                       exe_valid_o,
  input  logic                       exe_ready_i,
  output logic [DATA_WIDTH-1:0]      exe_src0_o,
  output logic [DATA_WIDTH-1:0]      exe_src1_o,
  output logic [PAYLOAD_WIDTH-1:0]   exe_payload_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_READ  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     w_handshake;
  logic                     w_accept;
  logic [PAYLOAD_WIDTH-1:0] r_payload;
  logic                     r_use0;
  logic                     r_use1;
  logic [DATA_WIDTH-1:0]    r_hold0;
  logic [DATA_WIDTH-1:0]    r_hold1;
  logic [DATA_WIDTH-1:0]    w_rd_op0;
  logic [DATA_WIDTH-1:0]    w_rd_op1;

  // The register file is addressed straight from the issue port, so its
  // data arrives exactly in the READ cycle that follows an accept.
  assign rf_raddr0_o = issue_psrc0_i;
  assign rf_raddr1_o = issue_psrc1_i;

  assign exe_valid_o   = (r_state != S_EMPTY);
  assign w_handshake   = exe_valid_o & exe_ready_i;
  assign issue_ready_o = ~flush_i & ((r_state == S_EMPTY) | w_handshake);
  assign w_accept      = issue_valid_i & issue_ready_o;
  assign exe_payload_o = r_payload;

`ifdef RR_WB_BYPASS_EN
  logic [TAG_W-1:0]      r_psrc0;
  logic [TAG_W-1:0]      r_psrc1;
  logic                  r_byp_hit0;
  logic                  r_byp_hit1;
  logic [DATA_WIDTH-1:0] r_byp_data0;
  logic [DATA_WIDTH-1:0] r_byp_data1;
  logic [DATA_WIDTH:0]   w_byp_issue0;
  logic [DATA_WIDTH:0]   w_byp_issue1;
  logic [DATA_WIDTH:0]   w_byp_held0;
  logic [DATA_WIDTH:0]   w_byp_held1;

  // Returns {hit, data} for a tag. The scan runs from the top port down,
  // so the lowest-indexed matching port wins.
  function automatic logic [DATA_WIDTH:0] wb_match(input logic [TAG_W-1:0] tag);
    logic [DATA_WIDTH:0] m;
    m = '0;
    for (int p = WB_W - 1; p >= 0; p--) begin
      if (wb_valid_i[p] && (wb_pdest_i[p*TAG_W +: TAG_W] == tag))
        m = {1'b1, wb_data_i[p*DATA_WIDTH +: DATA_WIDTH]};
    end
    return m;
  endfunction

  // Writeback comparators against the issuing tags and the held tags.
  always_comb begin
    w_byp_issue0 = wb_match(issue_psrc0_i);
    w_byp_issue1 = wb_match(issue_psrc1_i);
    w_byp_held0  = wb_match(r_psrc0);
    w_byp_held1  = wb_match(r_psrc1);
  end

  // READ-cycle operands: a bypass captured at issue beats the register file.
  always_comb begin
    w_rd_op0 = '0;
    w_rd_op1 = '0;
    if (r_use0) w_rd_op0 = r_byp_hit0 ? r_byp_data0 : rf_rdata0_i;
    if (r_use1) w_rd_op1 = r_byp_hit1 ? r_byp_data1 : rf_rdata1_i;
  end
`else
  // With no comparators the writeback port is not needed.
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_valid_i, wb_pdest_i, wb_data_i};

  // READ-cycle operands come straight from the write-through register file.
  always_comb begin
    w_rd_op0 = '0;
    w_rd_op1 = '0;
    if (r_use0) w_rd_op0 = rf_rdata0_i;
    if (r_use1) w_rd_op1 = rf_rdata1_i;
  end
`endif

  // Next-state logic. A flush overrides every other event.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_READ;
      S_READ,
      S_HOLD:  begin
        if (exe_ready_i) w_state_nxt = w_accept ? S_READ : S_EMPTY;
        else             w_state_nxt = S_HOLD;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    if (flush_i) w_state_nxt = S_EMPTY;
  end

  // State register. Reset beats flush and handshakes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Operand output mux. EMPTY drives zeros.
  always_comb begin
    exe_src0_o = '0;
    exe_src1_o = '0;
    case (r_state)
      S_READ:  begin exe_src0_o = w_rd_op0; exe_src1_o = w_rd_op1; end
      S_HOLD:  begin exe_src0_o = r_hold0;  exe_src1_o = r_hold1;  end
      default: ;
    endcase
  end

  // Op capture on accept, hold capture on a stalled READ, and hold refresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data and hold registers are cleared too, so a reset mid-op leaves no stale operands on the outputs.
      r_payload   <= '0;
      r_use0      <= 1'b0;
      r_use1      <= 1'b0;
      r_hold0     <= '0;
      r_hold1     <= '0;
`ifdef RR_WB_BYPASS_EN
      r_psrc0     <= '0;
      r_psrc1     <= '0;
      r_byp_hit0  <= 1'b0;
      r_byp_hit1  <= 1'b0;
      r_byp_data0 <= '0;
      r_byp_data1 <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_payload   <= issue_payload_i;
        r_use0      <= issue_psrc0_valid_i;
        r_use1      <= issue_psrc1_valid_i;
`ifdef RR_WB_BYPASS_EN
        r_psrc0     <= issue_psrc0_i;
        r_psrc1     <= issue_psrc1_i;
        r_byp_hit0  <= w_byp_issue0[DATA_WIDTH];
        r_byp_hit1  <= w_byp_issue1[DATA_WIDTH];
        r_byp_data0 <= w_byp_issue0[DATA_WIDTH-1:0];
        r_byp_data1 <= w_byp_issue1[DATA_WIDTH-1:0];
`endif
      end
      if (r_state == S_READ && !exe_ready_i) begin
        r_hold0 <= w_rd_op0;
        r_hold1 <= w_rd_op1;
      end
`ifdef RR_WB_BYPASS_EN
      else if (r_state == S_HOLD) begin
        if (r_use0 && w_byp_held0[DATA_WIDTH]) r_hold0 <= w_byp_held0[DATA_WIDTH-1:0];
        if (r_use1 && w_byp_held1[DATA_WIDTH]) r_hold1 <= w_byp_held1[DATA_WIDTH-1:0];
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_read_stage.sv
// tb_register_read_stage
// Self-checking bench for register_read_stage. It contains a synchronous-read
// register file that writebacks update. In the no-bypass build that file is
// write-through. A transaction-level model tracks the single op in flight:
// its payload, and the operand values the execution unit should see.
// Directed scenarios come first, then randomized traffic.

`ifndef PHY_REG_NUM
`define PHY_REG_NUM 64
`endif
`ifndef WB_WIDTH
`define WB_WIDTH 2
`endif

module tb_register_read_stage;
  localparam int DW   = 32;
  localparam int PW   = 64;
  localparam int NREG = `PHY_REG_NUM;
  localparam int TW   = $clog2(`PHY_REG_NUM);
  localparam int W    = `WB_WIDTH;

  logic          clk;
  logic          rst;
  logic          flush_i;
  logic          issue_valid_i;
  logic          issue_ready_o;
  logic [TW-1:0] issue_psrc0_i;
  logic [TW-1:0] issue_psrc1_i;
  logic          issue_psrc0_valid_i;
  logic          issue_psrc1_valid_i;
  logic [PW-1:0] issue_payload_i;
  logic [TW-1:0] rf_raddr0_o;
  logic [TW-1:0] rf_raddr1_o;
  logic [DW-1:0] rf_rdata0;
  logic [DW-1:0] rf_rdata1;
  logic          exe_valid_o;
  logic          exe_ready_i;
  logic [DW-1:0] exe_src0_o;
  logic [DW-1:0] exe_src1_o;
  logic [PW-1:0] exe_payload_o;

  logic          wb_v [W];
  logic [TW-1:0] wb_t [W];
  logic [DW-1:0] wb_d [W];
  logic [W-1:0]    wb_valid_flat;
  logic [W*TW-1:0] wb_pdest_flat;
  logic [W*DW-1:0] wb_data_flat;

  always_comb begin
    wb_valid_flat = '0;
    wb_pdest_flat = '0;
    wb_data_flat  = '0;
    for (int p = 0; p < W; p++) begin
      wb_valid_flat[p]          = wb_v[p];
      wb_pdest_flat[p*TW +: TW] = wb_t[p];
      wb_data_flat[p*DW +: DW]  = wb_d[p];
    end
  end

  register_read_stage #(.DATA_WIDTH(DW), .PAYLOAD_WIDTH(PW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush_i             (flush_i),
    .issue_valid_i       (issue_valid_i),
    .issue_ready_o       (issue_ready_o),
    .issue_psrc0_i       (issue_psrc0_i),
    .issue_psrc1_i       (issue_psrc1_i),
    .issue_psrc0_valid_i (issue_psrc0_valid_i),
    .issue_psrc1_valid_i (issue_psrc1_valid_i),
    .issue_payload_i     (issue_payload_i),
    .rf_raddr0_o         (rf_raddr0_o),
    .rf_raddr1_o         (rf_raddr1_o),
    .rf_rdata0_i         (rf_rdata0),
    .rf_rdata1_i         (rf_rdata1),
    .wb_valid_i          (wb_valid_flat),
    .wb_pdest_i          (wb_pdest_flat),
    .wb_data_i           (wb_data_flat),
    .exe_valid_o         (exe_valid_o),
    .exe_ready_i         (exe_ready_i),
    .exe_src0_o          (exe_src0_o),
    .exe_src1_o          (exe_src1_o),
    .exe_payload_o       (exe_payload_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- register file fixture ----------------
  logic [DW-1:0] rf [NREG];

  function automatic logic [DW-1:0] pat(input int i);
    return 32'h1000_0000 + i * 32'h0000_0101;
  endfunction

  // Lowest-indexed writeback port that targets the tag, if any.
  function automatic bit wb_hit(input logic [TW-1:0] tag, output logic [DW-1:0] d);
    d = '0;
    for (int p = 0; p < W; p++) begin
      if (wb_v[p] && wb_t[p] == tag) begin
        d = wb_d[p];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Most recent value of a register, including writebacks landing this cycle.
  function automatic logic [DW-1:0] newest(input logic [TW-1:0] tag);
    logic [DW-1:0] d;
    if (wb_hit(tag, d)) return d;
    return rf[tag];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= pat(i);
    end else begin
      for (int p = W - 1; p >= 0; p--) if (wb_v[p]) rf[wb_t[p]] <= wb_d[p];
    end
`ifdef RR_WB_BYPASS_EN
    rf_rdata0 <= rf[rf_raddr0_o];
    rf_rdata1 <= rf[rf_raddr1_o];
`else
    rf_rdata0 <= newest(rf_raddr0_o);
    rf_rdata1 <= newest(rf_raddr1_o);
`endif
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: the single op in flight ----------------
  bit            m_busy  = 1'b0;
  bit            m_fresh = 1'b0;  // op is in its first visible cycle
  bit            m_use0, m_use1;
  logic [TW-1:0] m_tag0, m_tag1;
  logic [DW-1:0] m_src0, m_src1;
  logic [PW-1:0] m_pay;

  // Called just after a rising edge. Checks outputs on the falling edge,
  // advances the model, then returns 1 ns after the next rising edge.
  task automatic step();
    bit            exp_ready, acc, hs;
    logic [DW-1:0] d;
    #4;
    exp_ready = !flush_i && (!m_busy || exe_ready_i);
    check("issue_ready", issue_ready_o, exp_ready);
    check("rf_raddr0", rf_raddr0_o, issue_psrc0_i);
    check("rf_raddr1", rf_raddr1_o, issue_psrc1_i);
    check("exe_valid", exe_valid_o, m_busy);
    if (m_busy) begin
      check("exe_src0", exe_src0_o, m_src0);
      check("exe_src1", exe_src1_o, m_src1);
      check("exe_payload", exe_payload_o, m_pay);
    end
    if (rst || flush_i) begin
      m_busy = 1'b0;
    end else begin
      hs  = m_busy && exe_ready_i;
      acc = issue_valid_i && exp_ready;
      if (m_busy && !hs) begin
`ifdef RR_WB_BYPASS_EN
        if (!m_fresh) begin
          if (m_use0 && wb_hit(m_tag0, d)) m_src0 = d;
          if (m_use1 && wb_hit(m_tag1, d)) m_src1 = d;
        end
`endif
        m_fresh = 1'b0;
      end
      if (hs) m_busy = 1'b0;
      if (acc) begin
        m_busy  = 1'b1;
        m_fresh = 1'b1;
        m_pay   = issue_payload_i;
        m_use0  = issue_psrc0_valid_i;
        m_use1  = issue_psrc1_valid_i;
        m_tag0  = issue_psrc0_i;
        m_tag1  = issue_psrc1_i;
        m_src0  = issue_psrc0_valid_i ? newest(issue_psrc0_i) : '0;
        m_src1  = issue_psrc1_valid_i ? newest(issue_psrc1_i) : '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rst                 = 1'b0;
    flush_i             = 1'b0;
    issue_valid_i       = 1'b0;
    issue_psrc0_i       = '0;
    issue_psrc1_i       = '0;
    issue_psrc0_valid_i = 1'b0;
    issue_psrc1_valid_i = 1'b0;
    issue_payload_i     = '0;
    exe_ready_i         = 1'b1;
    for (int p = 0; p < W; p++) begin
      wb_v[p] = 1'b0;
      wb_t[p] = '0;
      wb_d[p] = '0;
    end
  endtask

  task automatic issue(input int t0, input bit u0, input int t1, input bit u1, input logic [PW-1:0] pay);
    issue_valid_i       = 1'b1;
    issue_psrc0_i       = TW'(t0);
    issue_psrc0_valid_i = u0;
    issue_psrc1_i       = TW'(t1);
    issue_psrc1_valid_i = u1;
    issue_payload_i     = pay;
  endtask

  task automatic wb(input int p, input int t, input logic [DW-1:0] d);
    wb_v[p] = 1'b1;
    wb_t[p] = TW'(t);
    wb_d[p] = d;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_exe_valid", exe_valid_o, 0);
    check("rst_src0", exe_src0_o, 0);
    check("rst_src1", exe_src1_o, 0);
    check("rst_payload", exe_payload_o, 0);
    check("rst_issue_ready", issue_ready_o, 1);
    step();

    // Preload: RF[5]=0x11, RF[7]=0.
    idle(); wb(0, 5, 32'h11); wb(1, 7, 32'h0); step();

    // Single op, one used source, exe ready.
    idle(); issue(5, 1, 9, 0, 64'hA1); step();
    check("t31_valid", exe_valid_o, 1);
    check("t31_src0", exe_src0_o, 32'h11);
    check("t31_src1", exe_src1_o, 0);
    idle(); step();
    check("t31_empty", exe_valid_o, 0);

    // Back-to-back ops A then B.
    idle(); issue(1, 1, 2, 1, 64'hB0); step();
    check("t32_a_pay", exe_payload_o, 64'hB0);
    check("t32_a_src0", exe_src0_o, pat(1));
    check("t32_a_src1", exe_src1_o, pat(2));
    issue(3, 1, 4, 1, 64'hB1); step();
    check("t32_b_pay", exe_payload_o, 64'hB1);
    check("t32_b_src0", exe_src0_o, pat(3));
    check("t32_b_src1", exe_src1_o, pat(4));
    idle(); step();

    // Stall for three cycles while the RF and read addresses change.
    idle(); issue(3, 1, 4, 1, 64'hC0); exe_ready_i = 1'b0; step();
    for (int k = 0; k < 3; k++) begin
      idle(); exe_ready_i = 1'b0;
      issue_psrc0_i = TW'(20); issue_psrc1_i = TW'(10 + k);
      wb(0, 20, $urandom);
      step();
      check("t33_hold_valid", exe_valid_o, 1);
      check("t33_hold_src0", exe_src0_o, pat(3));
      check("t33_hold_src1", exe_src1_o, pat(4));
    end
    idle(); step();
    check("t33_release", exe_valid_o, 0);

    // Writeback in the issue cycle, then refreshes while held.
    idle(); issue(7, 1, 0, 0, 64'hD0); exe_ready_i = 1'b0; wb(1, 7, 32'hAB); step();
    check("t34_issue_wb", exe_src0_o, 32'hAB);
    idle(); exe_ready_i = 1'b0; step();
    idle(); exe_ready_i = 1'b0; wb(1, 7, 32'hCD); step();
`ifdef RR_WB_BYPASS_EN
    check("t34_hold_wb", exe_src0_o, 32'hCD);
`else
    check("t34_hold_wb", exe_src0_o, 32'hAB);
`endif
    idle(); exe_ready_i = 1'b0; wb(0, 7, 32'h55); wb(1, 7, 32'h66); step();
`ifdef RR_WB_BYPASS_EN
    check("t34_port_prio", exe_src0_o, 32'h55);
`else
    check("t34_port_prio", exe_src0_o, 32'hAB);
`endif
    idle(); step();

    // Flush during a stalled READ with a new op offered.
    idle(); issue(1, 1, 2, 1, 64'hE0); exe_ready_i = 1'b0; step();
    idle(); issue(3, 1, 4, 1, 64'hE1); flush_i = 1'b1; exe_ready_i = 1'b0; step();
    check("t35_valid", exe_valid_o, 0);

    // Reset while in HOLD.
    idle(); issue(2, 1, 3, 1, 64'hF0); exe_ready_i = 1'b0; step();
    idle(); exe_ready_i = 1'b0; step();
    idle(); rst = 1'b1; exe_ready_i = 1'b0; step();
    check("t36_valid", exe_valid_o, 0);
    check("t36_src0", exe_src0_o, 0);
    check("t36_src1", exe_src1_o, 0);
    check("t36_payload", exe_payload_o, 0);
    check("t36_issue_ready", issue_ready_o, 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      idle();
      rst                 = ($urandom_range(0, 79) == 0);
      flush_i             = ($urandom_range(0, 15) == 0);
      exe_ready_i         = ($urandom_range(0, 9) < 7);
      issue_valid_i       = ($urandom_range(0, 9) < 7);
      issue_psrc0_i       = ($urandom_range(0, 7) == 0) ? TW'($urandom_range(0, NREG - 1)) : TW'($urandom_range(0, 7));
      issue_psrc1_i       = TW'($urandom_range(0, 7));
      issue_psrc0_valid_i = ($urandom_range(0, 3) != 0);
      issue_psrc1_valid_i = ($urandom_range(0, 3) != 0);
      issue_payload_i     = {$urandom, $urandom};
      for (int p = 0; p < W; p++) begin
        if ($urandom_range(0, 1) == 1) wb(p, $urandom_range(0, 7), $urandom);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
